// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and state encoding shared by the UART transmitter and receiver
package uart_pkg;
  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS = 8;
  typedef enum logic [3:0] {
    IDLE, START, BIT_0, BIT_1, BIT_2, BIT_3, BIT_4, BIT_5, BIT_6, BIT_7, STOP
  } uart_state_e;
  function automatic logic is_data(uart_state_e s);
    return s >= BIT_0 && s <= BIT_7;
  endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, 16 ticks per bit, with a one-byte holding buffer
module uart_tx
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_tick_16x,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_ready,
  output logic       TxD,
  output logic       busy
);
  uart_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, hold;
  logic full, load, last, txd_n;
  assign TxD_ready = ~full;
  assign busy = state != IDLE;
  assign last = cnt == 4'(TICKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 4'd1;
    shreg_n = shreg;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        load = full;
      end
      START: state_n = last ? BIT_0 : START;
      STOP: begin
        state_n = last ? IDLE : STOP;
        load = last & full;
      end
      default: begin
        // data bits step through the consecutive encodings up to STOP; anything else is illegal
        state_n = !is_data(state) ? IDLE : last ? uart_state_e'(state + 4'd1) : state;
        shreg_n = is_data(state) && last ? shreg >> 1 : shreg;
        cnt_n = is_data(state) ? cnt + 4'd1 : '0;
      end
    endcase
    if (load) begin
      state_n = START;
      cnt_n = '0;
      shreg_n = hold;
    end
    txd_n = is_data(state_n) ? shreg_n[0] : state_n != START;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      hold <= '0;
      full <= 1'b0;
      TxD <= 1'b1;
    end else begin
      if (TxD_start && !full) begin
        hold <= TxD_data;
        full <= 1'b1;
      end else if (uart_tick_16x && load) begin
        full <= 1'b0;
      end
      if (uart_tick_16x) begin
        state <= state_n;
        cnt <= cnt_n;
        shreg <= shreg_n;
        TxD <= txd_n;
      end
    end
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have a single clock, `clock`; the reset SHALL be asynchronous and active-low.
REQ-002 Port `clock`: input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 Port `reset_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `uart_tick_16x`: input, 1 bit, one-clock enable pulse at 16x the baud rate.
REQ-005 Port `TxD_start`: input, 1 bit, byte-valid request.
REQ-006 Port `TxD_data`: input, 8 bits, byte to send; sampled only on acceptance.
REQ-007 Port `TxD_ready`: output, 1 bit, high when the holding buffer is empty and a byte can be accepted.
REQ-008 Port `TxD`: output, 1 bit, registered serial line; idle high.
REQ-009 Port `busy`: output, 1 bit, high while a frame is on the line (START through STOP).
REQ-010 The block SHALL have no parameters; the frame format is fixed at 8N1, LSB first, 16 ticks per bit.

Function
REQ-011 A byte SHALL be accepted on any clock edge where `TxD_start` and `TxD_ready` are both high, independent of `uart_tick_16x`.
- The byte is copied into a 1-entry holding buffer.
- `TxD_ready` goes low on the following cycle.
REQ-012 `TxD_start` while `TxD_ready` is low SHALL be ignored with no side effects.
REQ-013 The state machine SHALL have the states IDLE, START, BIT_0..BIT_7 and STOP, and SHALL advance only on cycles where `uart_tick_16x` is high.
REQ-014 A 4-bit tick counter SHALL count the ticks in each state; the state advances on the 16th tick (counter = 15), when the counter wraps to 0.
REQ-015 IDLE -> START SHALL occur on the first tick at which the holding buffer is full.
- On entering START: the buffer moves into an 8-bit shift register, the buffer is freed, and `TxD_ready` rises on the next cycle.
- The tick counter is cleared.
REQ-016 `TxD` SHALL be:
- 0 in START;
- shift-register bit 0 in BIT_n, with a right shift on each BIT_n exit;
- 1 in STOP and IDLE.
REQ-017 Each state SHALL hold `TxD` for exactly 16 ticks, so one frame spans 160 ticks.
REQ-018 STOP exit SHALL go to START if the buffer is full at that tick (no idle gap, back-to-back framing), and to IDLE otherwise.
REQ-019 A new byte SHALL be accepted while a frame is in progress (buffer empty), so that continuous streaming needs no wait states.
REQ-020 `busy` SHALL be high in every state except IDLE.
REQ-021 When `uart_tick_16x` is low, all state, counter, shift-register and `TxD` values SHALL hold, except holding-buffer acceptance.
REQ-022 Tick spacing SHALL be arbitrary (≥1 clock); back-to-back ticks on consecutive clocks SHALL be handled.
REQ-023 Illegal state encodings SHALL recover to IDLE with `TxD` = 1 on the next tick.

Reset
REQ-024 Asserting `reset_n` low SHALL immediately force the following, including mid-frame, and abort any frame in progress:
- state IDLE, tick counter 0;
- `TxD` = 1, `busy` = 0;
- holding buffer empty, `TxD_ready` = 1;
- shift register 0x00.
REQ-025 After reset release, the first accepted byte SHALL produce a complete, well-formed frame.

Structure
REQ-026 The state enumeration, `TICKS_PER_BIT` = 16 and `DATA_BITS` = 8 SHALL live in the shared `uart_pkg`, which the receiver also imports.
REQ-027 No sub-module is required; the 16x tick is supplied externally by the existing baud generator.

Verification
REQ-028 Send 0x55 with a tick every 4 clocks -> `TxD` = 0,1,0,1,0,1,0,1,0,1, each level held for 16 ticks (64 clocks); then idle high; `busy` high for exactly 160 ticks.
REQ-029 Accept 0xA5, then 0x3C as soon as `TxD_ready` returns -> two frames with no idle gap: the STOP of frame 1 is followed directly by the START of frame 2; 320 ticks total; the receiver loopback returns 0xA5 then 0x3C.
REQ-030 Assert `TxD_start` with 0xFF while the buffer is full -> the request is ignored; the line carries only the previously queued bytes.
REQ-031 Pull `reset_n` low during BIT_3 of 0x81 -> `TxD` = 1, `busy` = 0 and `TxD_ready` = 1 asynchronously; a following send of 0x0F produces a clean frame.
REQ-032 Hold `uart_tick_16x` low for 1000 clocks mid-BIT_5 -> `TxD` is stable; the frame resumes with the remaining tick count intact.
REQ-033 Drive ticks on every clock with a continuous stream 0x00..0x0F -> the receiver loopback matches all 16 bytes in order.
